mem_stage_pipe: RTL

Parametrised memory stage for the 16-bit pipelined core, replacing the fixed single-cycle data-memory and MEM/WB register pair. Drives a handshaked data-memory port with byte enables, sub-word (byte/half) loads and stores with sign or zero extension, and variable memory latency via a stall back to the hazard unit. Also registers the MEM/WB pipeline boundary.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_stage_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: access sizes, FSM states,
// W-stage result-source encodings and the lane-count helper.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10
  } state_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC2 = 2'b10;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replication and byte enables, plus
// load lane extraction with sign or zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  size_e                     size,
  input  logic [1:0]                offset,
  input  logic                      sign_ext,
  input  logic [DATA_W-1:0]         store_data,
  input  logic [DATA_W-1:0]         load_raw,
  output logic [DATA_W-1:0]         wdata,
  output logic [lane_count(DATA_W)-1:0] be,
  output logic [DATA_W-1:0]         load_data
);

  localparam int LANES = lane_count(DATA_W);

  int         byte_lane;
  int         half_lane;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_lane = int'(offset) % LANES;
  assign half_lane = (int'(offset) >> 1) % (LANES / 2);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    wdata     = store_data;
    be        = '0;
    load_data = load_raw;
    byte_val  = load_raw[8*byte_lane +: 8];
    half_val  = load_raw[16*half_lane +: 16];
    case (size)
      SIZE_BYTE: begin
        wdata         = {LANES{store_data[7:0]}};
        be[byte_lane] = 1'b1;
        load_data     = sign_ext ? DATA_W'($signed(byte_val)) : DATA_W'(byte_val);
      end
      SIZE_HALF: begin
        wdata                 = {(LANES/2){store_data[15:0]}};
        be[2*half_lane +: 2]  = 2'b11;
        load_data             = sign_ext ? DATA_W'($signed(half_val)) : DATA_W'(half_val);
      end
      default: begin
        be = '1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory stage with handshaked data-memory port and MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_CHK_EN.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          validM,
  input  logic                          regWriteM,
  input  logic                          memWriteM,
  input  logic                          memReadM,
  input  logic                          signedM,
  input  logic [1:0]                    sizeM,
  input  logic [1:0]                    resultSrcM,
  input  logic [ADDR_W-1:0]             aluResM,
  input  logic [DATA_W-1:0]             writeDataM,
  input  logic [DATA_W-1:0]             PCPlus2M,
  input  logic [REG_AW-1:0]             RdM,
  output logic                          stallM,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [lane_count(DATA_W)-1:0] mem_be,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          validW,
  output logic                          regWriteW,
  output logic                          misalignW,
  output logic [1:0]                    resultSrcW,
  output logic [REG_AW-1:0]             RdW,
  output logic [DATA_W-1:0]             aluResW,
  output logic [DATA_W-1:0]             readDataW,
  output logic [DATA_W-1:0]             writeDataW,
  output logic [DATA_W-1:0]             PCPlus2W
);

  size_e       size;
  state_e      state, state_next;
  logic        mem_op, is_store, misalign, complete, req_raw;
  logic [1:0]  offset;
  logic [DATA_W-1:0] load_data;

  assign size     = size_e'(sizeM);
  assign mem_op   = validM & (memReadM | memWriteM);
  assign is_store = memWriteM;

`ifdef MEM_STAGE_MISALIGN_CHK_EN
  assign misalign = mem_op & (((size == SIZE_HALF) & aluResM[0]) |
                              ((size == SIZE_WORD) & (|aluResM[1:0])));
`else
  assign misalign = 1'b0;
`endif

  // Offset bits below the access size never steer lanes; this is what makes
  // an unchecked misaligned access behave as the aligned one.
  always_comb begin
    offset = aluResM[1:0];
    case (size)
      SIZE_HALF: offset[0] = 1'b0;
      SIZE_WORD: offset    = 2'b00;
      default:   ;
    endcase
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size       (size),
    .offset     (offset),
    .sign_ext   (signedM),
    .store_data (writeDataM),
    .load_raw   (mem_rdata),
    .wdata      (mem_wdata),
    .be         (mem_be),
    .load_data  (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, REQ: begin
        if (req_raw) state_next = mem_gnt ? (is_store ? IDLE : WAIT_R) : REQ;
      end
      WAIT_R:  if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_raw  = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        req_raw  = mem_op & ~misalign;
        complete = validM & (~mem_op | misalign | (is_store & mem_gnt));
      end
      REQ: begin
        req_raw  = 1'b1;
        complete = is_store & mem_gnt;
      end
      WAIT_R:  complete = mem_rvalid;
      default: ;
    endcase
  end

  assign mem_req  = req_raw & rst;
  assign stallM   = rst & mem_op & ~complete;
  assign mem_we   = memWriteM;
  assign mem_addr = aluResM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validW     <= 1'b0;
      regWriteW  <= 1'b0;
      misalignW  <= 1'b0;
      resultSrcW <= '0;
      RdW        <= '0;
      aluResW    <= '0;
      readDataW  <= '0;
      writeDataW <= '0;
      PCPlus2W   <= '0;
    end else if (complete) begin
      validW     <= 1'b1;
      regWriteW  <= regWriteM & ~misalign;
      misalignW  <= misalign;
      resultSrcW <= resultSrcM;
      RdW        <= RdM;
      aluResW    <= DATA_W'(aluResM);
      readDataW  <= (mem_op & ~is_store & ~misalign) ? load_data : '0;
      writeDataW <= writeDataM;
      PCPlus2W   <= PCPlus2M;
    end else begin
      validW    <= 1'b0;
      regWriteW <= 1'b0;
    end
  end

endmodule
